pcie_axi_slv_mem: RTL and testbench
===================================

Name: pcie_axi_slv_mem

Overview:
- AXI4 slave memory model that terminates the PCIe-to-AXI bridge's m_axi master port (awaddr/wdata/bresp/araddr/rdata channels).
- Services FIXED and INCR bursts from an internal register array.
- Independent write and read FSMs, so one write burst and one read burst run concurrently.
- Gives the bridge real back-pressure and read data, so completion TLPs carry meaningful payload.

Parameters:
- AXI_ID_WIDTH, 8: width of awid/bid/arid/rid.
- AXI_ADDR_WIDTH, 16: byte address width.
- AXI_DATA_WIDTH, 256: data bus width in bits.
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8: write strobe width.
- MEM_AW, 8: log2 of memory depth in data-width words (256 words).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_axi_awid/awaddr/awlen/awsize/awburst  in  ID/ADDR/8/3/2  write address.
- s_axi_awvalid  in  1; s_axi_awready  out  1.
- s_axi_wdata/wstrb/wlast/wvalid  in  DATA/STRB/1/1; s_axi_wready  out  1.
- s_axi_bid  out  ID; s_axi_bresp  out  2; s_axi_bvalid  out  1; s_axi_bready  in  1.
- s_axi_arid/araddr/arlen/arsize/arburst  in  ID/ADDR/8/3/2  read address.
- s_axi_arvalid  in  1; s_axi_arready  out  1.
- s_axi_rid  out  ID; s_axi_rdata  out  DATA; s_axi_rresp  out  2; s_axi_rlast  out  1; s_axi_rvalid  out  1; s_axi_rready  in  1.
- (awlock/awcache/awprot and ar equivalents are not ports; the instantiating level leaves them unconnected.)

Behaviour:
- Reset (rst_n low, async):
  - Both FSMs go to IDLE.
  - awready=1, arready=1; wready, bvalid, rvalid, rlast = 0; bresp, rresp, bid, rid, rdata = 0.
  - Memory contents are not reset and are retained.
  - Reset mid-burst abandons the burst; no response is issued.
- Word index = addr[MEM_AW+log2(STRB)-1 : log2(STRB)]; upper address bits are ignored (memory aliases).
- Beat address step: INCR adds (1<<size), then aligns down to size; FIXED does not advance.
- WRAP (2'b10) or reserved (2'b11) burst: data is accepted/returned normally, no memory write, response is SLVERR.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On the aw handshake, latch id/addr/len/size/burst, load beat counter = awlen, go to W_DATA (awready=0).
  - W_DATA: wready=1. Each w handshake writes the bytes enabled by wstrb, advances the address and decrements the counter.
  - Leave W_DATA after beat awlen+1. Termination uses the beat count; wlast does not terminate.
  - wlast mismatch: wlast=1 on a non-final beat, or 0 on the final beat, gives bresp SLVERR.
  - W_RESP: bvalid=1, bid = latched id, bresp OKAY unless an error was flagged. Hold until bready, then W_IDLE.
  - Latency: bvalid asserts in the cycle after the final w handshake.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: arready=1. On the ar handshake, latch fields and register beat 0 (combinational array read). rvalid=1 the next cycle.
  - R_DATA: rdata/rid/rresp/rlast hold while rvalid && !rready.
  - On each r handshake the next beat is registered the same edge, giving one beat per cycle with no bubbles.
  - rlast=1 on beat arlen. After its handshake, rvalid=0 and go to R_IDLE.
- Read/write collision on the same word in the same cycle: the read beat returns pre-write data.
- Back-to-back: a new aw is accepted the cycle after the b handshake; a new ar is accepted the cycle after the last r handshake.
- A len of 255 is supported; the counter is 8 bits.

Optional Feature:
- Macro AXI_SLV_MEM_BACKPRESSURE_EN.
- When defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every cycle.
  - LFSR bit0=0 forces wready=0 in W_DATA.
  - LFSR bit1=0 keeps the next read beat from being presented; rvalid stays 0 until the bit is 1. A beat that is already valid is never withdrawn.
- When undefined: no LFSR; full-throughput behaviour as above.

Decomposition:
- Package pcie_axi_mem_pkg holds:
  - burst_e (FIXED, INCR, WRAP, RSVD) and resp_e (OKAY, EXOKAY, SLVERR, DECERR).
  - wr_state_e and rd_state_e.
  - Function next_addr(addr, size, burst).
- One sub-module, pcie_axi_slv_mem_ram: 1 write port with byte enables, 1 asynchronous read port, depth 2**MEM_AW.

Test Plan:
- Write INCR, awaddr=16'h0040, len=3, size=5, strb all 1s, data 1..4 -> bresp=OKAY, bid echoes 8'h5A. Read the same burst -> rdata 1..4, rlast on beat 3 only, rresp=OKAY.
- Partial strobe: write 0xFF.. to word 2, then write 0x00.. with wstrb=32'h0000_000F -> readback has the low 4 bytes 00, the rest FF.
- FIXED burst len=3 to 16'h0100 with data A,B,C,D -> word 8 reads D, the neighbouring words are unchanged.
- WRAP burst (awburst=2'b10) len=1 -> bresp=SLVERR, target memory unchanged. wlast asserted on beat 0 of len=2 -> 3 beats still accepted, bresp=SLVERR.
- Read len=7 with rready toggling 1010... -> rdata stable while stalled, 8 beats in order, no beat lost or duplicated. Concurrent write to another word completes independently.
- Assert rst_n=0 on write beat 2 of 4 and on read beat 1 -> next cycle bvalid=rvalid=wready=0, awready=arready=1. Earlier-written words are retained.

Source files
------------

// File: rtl/pcie_axi_slv_mem_pkg.sv
// Shared types and helpers for the AXI4 slave memory model.
//   burst_e / resp_e : AXI burst type and response encodings
//   wr_state_e       : write channel FSM states
//   rd_state_e       : read channel FSM states
//   next_addr()      : beat-to-beat address step for FIXED/INCR bursts
package pcie_axi_mem_pkg;

   typedef enum logic [1:0] {
      BurstFixed = 2'b00,
      BurstIncr  = 2'b01,
      BurstWrap  = 2'b10,
      BurstRsvd  = 2'b11
   } burst_e;

   typedef enum logic [1:0] {
      RespOkay   = 2'b00,
      RespExokay = 2'b01,
      RespSlverr = 2'b10,
      RespDecerr = 2'b11
   } resp_e;

   typedef enum logic [1:0] {
      WIdle = 2'b00,
      WData = 2'b01,
      WResp = 2'b10
   } wr_state_e;

   typedef enum logic {
      RIdle = 1'b0,
      RData = 1'b1
   } rd_state_e;

   // Works on a wide address so any instance address width fits; callers truncate.
   // INCR adds one transfer size then aligns down; everything else holds the address.
   function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                             input logic [2:0]  size,
                                             input logic [1:0]  burst);
      logic [63:0] step;
      step = 64'd1 << size;
      if (burst == BurstIncr) begin
         next_addr = (addr + step) & ~(step - 64'd1);
      end else begin
         next_addr = addr;
      end
   endfunction

endpackage

// File: rtl/pcie_axi_slv_mem_ram.sv
// Word-wide register array with byte-enabled write and asynchronous read.
//   clk   : write clock
//   we    : write enable; wstrb selects bytes of wdata written to word waddr
//   raddr : combinational read address; rdata shows the pre-edge contents
// Contents have no reset.
module pcie_axi_slv_mem_ram #(
   parameter int unsigned DATA_WIDTH = 256,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned AW         = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [STRB_WIDTH-1:0] wstrb,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < int'(STRB_WIDTH); i++) begin
            if (wstrb[i]) begin
               mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/pcie_axi_slv_mem.sv
// AXI4 slave memory model terminating the bridge's AXI master port.
//   s_axi_aw* / s_axi_w* / s_axi_b* : write address, data and response channels
//   s_axi_ar* / s_axi_r*            : read address and data channels
// Independent write and read FSMs; FIXED/INCR bursts hit memory, WRAP/reserved
// bursts move data but answer SLVERR without writing.
// Optional macro AXI_SLV_MEM_BACKPRESSURE_EN adds LFSR-driven wready/rvalid stalls.
module pcie_axi_slv_mem
   import pcie_axi_mem_pkg::*;
#(
   parameter int unsigned AXI_ID_WIDTH   = 8,
   parameter int unsigned AXI_ADDR_WIDTH = 16,
   parameter int unsigned AXI_DATA_WIDTH = 256,
   parameter int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
   parameter int unsigned MEM_AW         = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid,
   input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic [7:0]                s_axi_awlen,
   input  logic [2:0]                s_axi_awsize,
   input  logic [1:0]                s_axi_awburst,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
   input  logic [AXI_STRB_WIDTH-1:0] s_axi_wstrb,
   input  logic                      s_axi_wlast,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic [AXI_ID_WIDTH-1:0]   s_axi_bid,
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
   input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [7:0]                s_axi_arlen,
   input  logic [2:0]                s_axi_arsize,
   input  logic [1:0]                s_axi_arburst,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
   output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
   output logic [1:0]                s_axi_rresp,
   output logic                      s_axi_rlast,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready
);

   localparam int unsigned OffW = $clog2(AXI_STRB_WIDTH);

   logic wr_ok, rd_ok;

`ifdef AXI_SLV_MEM_BACKPRESSURE_EN
   logic [15:0] lfsr_q;

   // Fibonacci LFSR, taps 16,14,13,11
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= 16'hACE1;
      else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   assign wr_ok = lfsr_q[0];
   assign rd_ok = lfsr_q[1];
`else
   assign wr_ok = 1'b1;
   assign rd_ok = 1'b1;
`endif

   // ---------------- write channel ----------------
   wr_state_e                 wr_state_q, wr_state_d;
   logic [AXI_ID_WIDTH-1:0]   wid_q, wid_d;
   logic [AXI_ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [2:0]                wsize_q, wsize_d;
   logic [1:0]                wburst_q, wburst_d;
   logic [7:0]                wcnt_q, wcnt_d;
   logic                      werr_q, werr_d;
   logic                      mem_we, w_hs;

   assign s_axi_awready = (wr_state_q == WIdle);
   assign s_axi_wready  = (wr_state_q == WData) && wr_ok;
   assign s_axi_bvalid  = (wr_state_q == WResp);
   assign s_axi_bid     = wid_q;
   assign s_axi_bresp   = werr_q ? RespSlverr : RespOkay;
   assign w_hs          = s_axi_wvalid && s_axi_wready;

   always_comb begin
      wr_state_d = wr_state_q;
      wid_d      = wid_q;
      waddr_d    = waddr_q;
      wsize_d    = wsize_q;
      wburst_d   = wburst_q;
      wcnt_d     = wcnt_q;
      werr_d     = werr_q;
      mem_we     = 1'b0;
      unique case (wr_state_q)
         WIdle: begin
            if (s_axi_awvalid) begin
               wid_d      = s_axi_awid;
               waddr_d    = s_axi_awaddr;
               wsize_d    = s_axi_awsize;
               wburst_d   = s_axi_awburst;
               wcnt_d     = s_axi_awlen;
               werr_d     = s_axi_awburst[1];  // WRAP or reserved
               wr_state_d = WData;
            end
         end
         WData: begin
            if (w_hs) begin
               mem_we  = !wburst_q[1];
               // beat count ends the burst; wlast is only checked
               if (s_axi_wlast != (wcnt_q == 8'd0)) werr_d = 1'b1;
               waddr_d = AXI_ADDR_WIDTH'(next_addr(64'(waddr_q), wsize_q, wburst_q));
               wcnt_d  = wcnt_q - 8'd1;
               if (wcnt_q == 8'd0) wr_state_d = WResp;
            end
         end
         WResp: begin
            if (s_axi_bready) wr_state_d = WIdle;
         end
         default: wr_state_d = WIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state_q <= WIdle;
         wid_q      <= '0;
         waddr_q    <= '0;
         wsize_q    <= '0;
         wburst_q   <= '0;
         wcnt_q     <= '0;
         werr_q     <= 1'b0;
      end else begin
         wr_state_q <= wr_state_d;
         wid_q      <= wid_d;
         waddr_q    <= waddr_d;
         wsize_q    <= wsize_d;
         wburst_q   <= wburst_d;
         wcnt_q     <= wcnt_d;
         werr_q     <= werr_d;
      end
   end

   // ---------------- read channel ----------------
   rd_state_e                 rd_state_q, rd_state_d;
   logic [AXI_ID_WIDTH-1:0]   rid_q, rid_d;
   logic [AXI_ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [2:0]                rsize_q, rsize_d;
   logic [1:0]                rburst_q, rburst_d;
   logic [7:0]                rcnt_q, rcnt_d;
   logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]                rresp_q, rresp_d;
   logic                      rlast_q, rlast_d;
   logic                      rvalid_q, rvalid_d;
   logic                      fetch;
   logic [AXI_ADDR_WIDTH-1:0] rd_addr;
   logic [7:0]                rd_cnt;
   logic [2:0]                rd_size;
   logic [1:0]                rd_burst;
   logic [AXI_DATA_WIDTH-1:0] rd_word;

   assign s_axi_arready = (rd_state_q == RIdle);
   assign s_axi_rid     = rid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rlast   = rlast_q;
   assign s_axi_rvalid  = rvalid_q;

   // Beat 0 is fetched straight off the AR channel so rvalid follows arvalid by one cycle
   always_comb begin
      if (rd_state_q == RIdle) begin
         rd_addr  = s_axi_araddr;
         rd_cnt   = s_axi_arlen;
         rd_size  = s_axi_arsize;
         rd_burst = s_axi_arburst;
      end else begin
         rd_addr  = raddr_q;
         rd_cnt   = rcnt_q;
         rd_size  = rsize_q;
         rd_burst = rburst_q;
      end
   end

   always_comb begin
      rd_state_d = rd_state_q;
      rid_d      = rid_q;
      raddr_d    = raddr_q;
      rsize_d    = rsize_q;
      rburst_d   = rburst_q;
      rcnt_d     = rcnt_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      rlast_d    = rlast_q;
      rvalid_d   = rvalid_q;
      fetch      = 1'b0;
      unique case (rd_state_q)
         RIdle: begin
            if (s_axi_arvalid) begin
               rid_d      = s_axi_arid;
               raddr_d    = s_axi_araddr;
               rsize_d    = s_axi_arsize;
               rburst_d   = s_axi_arburst;
               rcnt_d     = s_axi_arlen;
               rd_state_d = RData;
               fetch      = rd_ok;
            end
         end
         RData: begin
            if (rvalid_q && s_axi_rready) begin
               rvalid_d = 1'b0;
               rlast_d  = 1'b0;
               if (rlast_q) rd_state_d = RIdle;
               else         fetch      = rd_ok;
            end else if (!rvalid_q) begin
               fetch = rd_ok;
            end
         end
         default: rd_state_d = RIdle;
      endcase
      if (fetch) begin
         rdata_d  = rd_word;
         rvalid_d = 1'b1;
         rlast_d  = (rd_cnt == 8'd0);
         rresp_d  = rd_burst[1] ? RespSlverr : RespOkay;
         raddr_d  = AXI_ADDR_WIDTH'(next_addr(64'(rd_addr), rd_size, rd_burst));
         rcnt_d   = rd_cnt - 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state_q <= RIdle;
         rid_q      <= '0;
         raddr_q    <= '0;
         rsize_q    <= '0;
         rburst_q   <= '0;
         rcnt_q     <= '0;
         rdata_q    <= '0;
         rresp_q    <= '0;
         rlast_q    <= 1'b0;
         rvalid_q   <= 1'b0;
      end else begin
         rd_state_q <= rd_state_d;
         rid_q      <= rid_d;
         raddr_q    <= raddr_d;
         rsize_q    <= rsize_d;
         rburst_q   <= rburst_d;
         rcnt_q     <= rcnt_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         rlast_q    <= rlast_d;
         rvalid_q   <= rvalid_d;
      end
   end

   pcie_axi_slv_mem_ram #(
      .DATA_WIDTH (AXI_DATA_WIDTH),
      .STRB_WIDTH (AXI_STRB_WIDTH),
      .AW         (MEM_AW)
   ) u_ram (
      .clk   (clk),
      .we    (mem_we),
      .waddr (waddr_q[MEM_AW+OffW-1:OffW]),
      .wdata (s_axi_wdata),
      .wstrb (s_axi_wstrb),
      .raddr (rd_addr[MEM_AW+OffW-1:OffW]),
      .rdata (rd_word)
   );

endmodule

// File: tb/tb_pcie_axi_slv_mem.sv
// Self-checking bench for pcie_axi_slv_mem: reference memory model plus
// scoreboard queues for read data and write responses.
module tb_pcie_axi_slv_mem;

   localparam int DW = 256;
   localparam int SW = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [7:0]      awid = '0, arid = '0, bid, rid;
   logic [15:0]     awaddr = '0, araddr = '0;
   logic [7:0]      awlen = '0, arlen = '0;
   logic [2:0]      awsize = '0, arsize = '0;
   logic [1:0]      awburst = '0, arburst = '0, bresp, rresp;
   logic            awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
   logic [DW-1:0]   wdata = '0, rdata;
   logic [SW-1:0]   wstrb = '0;
   logic            bvalid, bready = 1'b0, arvalid = 1'b0, arready;
   logic            rlast, rvalid, rready = 1'b0;

   always #5 clk = ~clk;

   pcie_axi_slv_mem dut (
      .clk (clk), .rst_n (rst_n),
      .s_axi_awid (awid), .s_axi_awaddr (awaddr), .s_axi_awlen (awlen),
      .s_axi_awsize (awsize), .s_axi_awburst (awburst), .s_axi_awvalid (awvalid),
      .s_axi_awready (awready),
      .s_axi_wdata (wdata), .s_axi_wstrb (wstrb), .s_axi_wlast (wlast),
      .s_axi_wvalid (wvalid), .s_axi_wready (wready),
      .s_axi_bid (bid), .s_axi_bresp (bresp), .s_axi_bvalid (bvalid), .s_axi_bready (bready),
      .s_axi_arid (arid), .s_axi_araddr (araddr), .s_axi_arlen (arlen),
      .s_axi_arsize (arsize), .s_axi_arburst (arburst), .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_rid (rid), .s_axi_rdata (rdata), .s_axi_rresp (rresp), .s_axi_rlast (rlast),
      .s_axi_rvalid (rvalid), .s_axi_rready (rready)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] model [0:255];
   logic [DW-1:0] wbuf  [0:15];
   logic [DW-1:0] exp_rdata_q [$];
   logic [9:0]    exp_b_q [$];

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                           input logic [SW-1:0] s);
      merge = old;
      for (int i = 0; i < SW; i++) if (s[i]) merge[i*8 +: 8] = nw[i*8 +: 8];
   endfunction

   // abort_after >= 0: return (no response) once that many beats have been accepted
   task automatic write_burst(input logic [7:0] id, input logic [15:0] addr, input int len,
                              input logic [1:0] burst, input logic [SW-1:0] strb,
                              input int bad_last, input logic [1:0] exp_resp,
                              input int abort_after);
      int w, cyc;
      logic hs;
      logic [9:0] eb;
      awid = id; awaddr = addr; awlen = len[7:0]; awsize = 3'd5; awburst = burst;
      awvalid = 1'b1;
      cyc = 0;
      do begin @(negedge clk); hs = awready; @(posedge clk); #1; cyc++; end
      while (!hs && cyc < 50);
      awvalid = 1'b0;
      n_checks++;
      if (!hs) begin n_fail++; $display("FAIL aw_handshake: awready=0, required 1"); return; end
      w = int'(addr[12:5]);
      for (int b = 0; b <= len; b++) begin
         wdata = wbuf[b]; wstrb = strb; wlast = (b == len) || (b == bad_last); wvalid = 1'b1;
         cyc = 0;
         do begin @(negedge clk); hs = wready; @(posedge clk); #1; cyc++; end
         while (!hs && cyc < 50);
         n_checks++;
         if (!hs) begin
            n_fail++; wvalid = 1'b0;
            $display("FAIL w_handshake beat %0d: wready=0, required 1", b);
            return;
         end
         if (!burst[1]) model[w] = merge(model[w], wbuf[b], strb);
         if (burst == 2'b01) w = (w + 1) % 256;
         if (abort_after >= 0 && b + 1 == abort_after) begin wvalid = 1'b0; return; end
      end
      wvalid = 1'b0; wlast = 1'b0;
      exp_b_q.push_back({id, exp_resp});
      @(negedge clk);
      n_checks++;
      if (bvalid !== 1'b1) begin
         n_fail++; $display("FAIL b_latency: bvalid=%b, required 1", bvalid);
      end
      bready = 1'b1;
      cyc = 0;
      while (bvalid !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
      eb = exp_b_q.pop_front();
      n_checks++;
      if ({bvalid, bid, bresp} !== {1'b1, eb}) begin
         n_fail++;
         $display("FAIL b_resp: bvalid=%b bid=%h bresp=%0d, required 1 %h %0d",
                  bvalid, bid, bresp, eb[9:2], eb[1:0]);
      end
      @(posedge clk); #1; bready = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({awready, bvalid} !== 2'b10) begin
         n_fail++; $display("FAIL b2b_aw: awready=%b bvalid=%b, required 1 0", awready, bvalid);
      end
      @(posedge clk); #1;
   endtask

   task automatic read_burst(input logic [7:0] id, input logic [15:0] addr, input int len,
                             input bit toggle, input int abort_after);
      int w, cyc, beat;
      logic hs, stalled;
      logic [DW-1:0] held, exp;
      w = int'(addr[12:5]);
      for (int b = 0; b <= len; b++) begin exp_rdata_q.push_back(model[w]); w = (w + 1) % 256; end
      arid = id; araddr = addr; arlen = len[7:0]; arsize = 3'd5; arburst = 2'b01;
      arvalid = 1'b1;
      cyc = 0;
      do begin @(negedge clk); hs = arready; @(posedge clk); #1; cyc++; end
      while (!hs && cyc < 50);
      arvalid = 1'b0;
      n_checks++;
      if (!hs) begin n_fail++; $display("FAIL ar_handshake: arready=0, required 1"); return; end
      beat = 0; cyc = 0; stalled = 1'b0; held = '0;
      while (beat <= len && cyc < 200) begin
         rready = toggle ? ((cyc % 2) == 0) : 1'b1;
         @(negedge clk);
         if (rvalid) begin
            if (stalled) begin
               n_checks++;
               if (rdata !== held) begin
                  n_fail++; $display("FAIL r_stall_hold beat %0d: rdata=%h, required %h",
                                     beat, rdata, held);
               end
            end
            if (rready) begin
               exp = exp_rdata_q.pop_front();
               n_checks++;
               if (rdata !== exp) begin
                  n_fail++; $display("FAIL r_data beat %0d: rdata=%h, required %h", beat, rdata, exp);
               end
               n_checks++;
               if ({rid, rresp, rlast} !== {id, 2'b00, beat == len}) begin
                  n_fail++; $display("FAIL r_ctrl beat %0d: rid=%h rresp=%0d rlast=%b, required %h 0 %b",
                                     beat, rid, rresp, rlast, id, beat == len);
               end
               beat++; stalled = 1'b0;
               if (abort_after >= 0 && beat == abort_after) begin
                  @(posedge clk); #1; rready = 1'b0; return;
               end
            end else begin
               stalled = 1'b1; held = rdata;
            end
         end
         @(posedge clk); #1; cyc++;
      end
      rready = 1'b0;
      n_checks++;
      if (beat <= len) begin
         n_fail++; $display("FAIL r_timeout: beats=%0d, required %0d", beat, len + 1);
         return;
      end
      @(negedge clk);
      n_checks++;
      if ({rvalid, arready} !== 2'b01) begin
         n_fail++; $display("FAIL r_end: rvalid=%b arready=%b, required 0 1", rvalid, arready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b110000) begin
         n_fail++; $display("FAIL reset_ctrl: aw/ar/w/b/rv/rl=%b%b%b%b%b%b, required 110000",
                            awready, arready, wready, bvalid, rvalid, rlast);
      end
      n_checks++;
      if ({bresp, rresp, bid, rid} !== 20'h0 || rdata !== '0) begin
         n_fail++; $display("FAIL reset_data: bresp=%0d rresp=%0d bid=%h rid=%h rdata=%h, required 0",
                            bresp, rresp, bid, rid, rdata);
      end
      @(posedge clk); #1; rst_n = 1'b1;
   endtask

   task automatic test_incr();
      for (int i = 0; i < 4; i++) wbuf[i] = DW'(i + 1);
      write_burst(8'h5A, 16'h0040, 3, 2'b01, '1, -1, 2'b00, -1);
      read_burst(8'hA5, 16'h0040, 3, 1'b0, -1);
   endtask

   task automatic test_partial_strobe();
      wbuf[0] = '1;
      write_burst(8'h01, 16'h0040, 0, 2'b01, '1, -1, 2'b00, -1);
      wbuf[0] = '0;
      write_burst(8'h02, 16'h0040, 0, 2'b01, 32'h0000_000F, -1, 2'b00, -1);
      n_checks++;
      if (model[2] !== {{28{8'hFF}}, 32'h0}) begin
         n_fail++; $display("FAIL strobe_model: word2=%h, required low 4 bytes 00", model[2]);
      end
      read_burst(8'h03, 16'h0040, 0, 1'b0, -1);
   endtask

   task automatic test_fixed();
      for (int i = 0; i < 3; i++) wbuf[i] = {8{32'h7000_0000 + i}};
      write_burst(8'h10, 16'h00E0, 2, 2'b01, '1, -1, 2'b00, -1);
      for (int i = 0; i < 4; i++) wbuf[i] = DW'(32'hA + i);
      write_burst(8'h11, 16'h0100, 3, 2'b00, '1, -1, 2'b00, -1);
      read_burst(8'h12, 16'h00E0, 2, 1'b0, -1);
   endtask

   task automatic test_errors();
      wbuf[0] = {8{32'h1234_5678}};
      write_burst(8'h20, 16'h0280, 0, 2'b01, '1, -1, 2'b00, -1);
      wbuf[0] = '0; wbuf[1] = '1;
      write_burst(8'h21, 16'h0280, 1, 2'b10, '1, -1, 2'b10, -1);
      read_burst(8'h22, 16'h0280, 0, 1'b0, -1);
      for (int i = 0; i < 3; i++) wbuf[i] = DW'(32'hC0 + i);
      write_burst(8'h23, 16'h0300, 2, 2'b01, '1, 0, 2'b10, -1);
      read_burst(8'h24, 16'h0300, 2, 1'b0, -1);
   endtask

   task automatic test_stall_concurrent();
      for (int i = 0; i < 8; i++) wbuf[i] = {8{32'hB000_0000 + i}};
      write_burst(8'h30, 16'h0400, 7, 2'b01, '1, -1, 2'b00, -1);
      for (int i = 0; i < 2; i++) wbuf[i] = {4{64'hD00D_0000_0000_0000 + i}};
      fork
         read_burst(8'h31, 16'h0400, 7, 1'b1, -1);
         write_burst(8'h32, 16'h0800, 1, 2'b01, '1, -1, 2'b00, -1);
      join
      read_burst(8'h33, 16'h0800, 1, 1'b0, -1);
   endtask

   task automatic test_reset_mid_burst();
      for (int i = 0; i < 4; i++) wbuf[i] = {8{32'hE000_0000 + i}};
      write_burst(8'h40, 16'h0600, 3, 2'b01, '1, -1, 2'b00, 2);
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bvalid, wready, awready, arready} !== 4'b0011) begin
         n_fail++; $display("FAIL rst_mid_write: bvalid=%b wready=%b awready=%b arready=%b, required 0011",
                            bvalid, wready, awready, arready);
      end
      @(posedge clk); #1; rst_n = 1'b1;
      read_burst(8'h41, 16'h0040, 3, 1'b0, 1);
      rst_n = 1'b0;
      exp_rdata_q.delete();
      @(negedge clk);
      n_checks++;
      if ({rvalid, rlast, bvalid, wready, awready, arready} !== 6'b000011) begin
         n_fail++; $display("FAIL rst_mid_read: rvalid=%b rlast=%b bvalid=%b wready=%b aw=%b ar=%b, required 000011",
                            rvalid, rlast, bvalid, wready, awready, arready);
      end
      @(posedge clk); #1; rst_n = 1'b1;
      read_burst(8'h42, 16'h0600, 1, 1'b0, -1);
      read_burst(8'h43, 16'h0040, 3, 1'b0, -1);
   endtask

   initial begin
      test_reset();
      test_incr();
      test_partial_strobe();
      test_fixed();
      test_errors();
      test_stall_concurrent();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
